rst_sequencer: RTL and testbench

- Synthesizable reset sequencer: the responder end of the test-bench reset-request protocol.
- Test or control logic raises a one-cycle `rst_req`. The block drives a stretched, clean `dut_reset` into `dut_top`, waits a settle window, then returns a one-cycle `rst_ack`.
- Sits between the bench/system reset source and `dut_top`. Replaces ad-hoc event-triggered reset pulses with a deterministic, cycle-exact sequence.

---
 rtl/rst_sequencer.sv | 148 ++++++++++++++
 tb/tb_rst_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// Reset sequencer: turns a one-cycle rst_req into a stretched dut_reset, a settle
// window and a one-cycle rst_ack, with a power-on sequence after the system reset.
module rst_sequencer #(
    parameter int unsigned HOLD_CYCLES   = 2,
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter int unsigned COUNT_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rst_req,
    output logic               dut_reset,
    output logic               busy,
    output logic               rst_ack,
    output logic               req_merged,
    output logic [COUNT_W-1:0] rst_count
);

    localparam int unsigned MAX_CYC = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0]   HOLD_LD   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]   SETTLE_LD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    typedef enum logic [2:0] {
        S_POR,
        S_ASSERT,
        S_SETTLE,
        S_ACK,
        S_IDLE
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               pending, pending_nxt;
    logic               from_por, from_por_nxt;
    logic               merged_nxt;
    logic [COUNT_W-1:0] count_nxt;
    logic               dut_reset_nxt, busy_nxt, rst_ack_nxt;

    // State and registered outputs; reset aborts any sequence and restarts POR
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_POR;
            cnt        <= HOLD_LD;
            pending    <= 1'b0;
            from_por   <= 1'b1;
            req_merged <= 1'b0;
            rst_count  <= '0;
            dut_reset  <= 1'b1;
            busy       <= 1'b1;
            rst_ack    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pending    <= pending_nxt;
            from_por   <= from_por_nxt;
            req_merged <= merged_nxt;
            rst_count  <= count_nxt;
            dut_reset  <= dut_reset_nxt;
            busy       <= busy_nxt;
            rst_ack    <= rst_ack_nxt;
        end
    end

    // Next state, counter, request bookkeeping and next output values
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        pending_nxt   = pending;
        from_por_nxt  = from_por;
        merged_nxt    = req_merged;
        count_nxt     = rst_count;
        dut_reset_nxt = 1'b0;
        busy_nxt      = 1'b0;
        rst_ack_nxt   = 1'b0;

        // A request while a sequence runs is queued once; further ones collapse
        if (rst_req && (state == S_POR || state == S_ASSERT || state == S_SETTLE)) begin
            if (pending) begin
                merged_nxt = 1'b1;
            end else begin
                pending_nxt = 1'b1;
            end
        end

        case (state)
            S_POR: begin
                if (cnt == CNT_ONE) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_SETTLE;
                        cnt_nxt   = SETTLE_LD;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            S_ASSERT: begin
                if (cnt == CNT_ONE) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_nxt = S_ACK;
                    end else begin
                        state_nxt = S_SETTLE;
                        cnt_nxt   = SETTLE_LD;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            S_SETTLE: begin
                if (cnt == CNT_ONE) begin
                    state_nxt = from_por ? S_IDLE : S_ACK;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            S_ACK, S_IDLE: begin
                if (rst_req && pending) begin
                    merged_nxt = 1'b1;
                end
                if (rst_req || pending) begin
                    state_nxt    = S_ASSERT;
                    cnt_nxt      = HOLD_LD;
                    pending_nxt  = 1'b0;
                    from_por_nxt = 1'b0;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_POR;
                cnt_nxt   = HOLD_LD;
            end
        endcase

        if (state_nxt == S_ACK && rst_count != COUNT_MAX) begin
            count_nxt = rst_count + COUNT_W'(1);
        end

        dut_reset_nxt = (state_nxt == S_POR) || (state_nxt == S_ASSERT);
        busy_nxt      = (state_nxt != S_IDLE);
        rst_ack_nxt   = (state_nxt == S_ACK);
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: two instances (with and without a settle window) checked
// every cycle against a timeline model of the request/reset sequences.
module tb_rst_sequencer;

    localparam int H    = 2;
    localparam int S_A  = 3;
    localparam int S_B  = 0;
    localparam int CW   = 4;
    localparam int SAT  = (1 << CW) - 1;

    localparam int K_POR  = 0;
    localparam int K_REQ  = 1;
    localparam int K_IDLE = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          rst_req;
    logic          dut_reset_a, busy_a, rst_ack_a, req_merged_a;
    logic [CW-1:0] rst_count_a;
    logic          dut_reset_b, busy_b, rst_ack_b, req_merged_b;
    logic [CW-1:0] rst_count_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: sequence kind, the cycle its first output cycle occurs, request flags
    int m_kind   [2];
    int m_start  [2];
    int m_pend   [2];
    int m_merged [2];
    int m_count  [2];

    rst_sequencer #(.HOLD_CYCLES(H), .SETTLE_CYCLES(S_A), .COUNT_W(CW)) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .rst_req    (rst_req),
        .dut_reset  (dut_reset_a),
        .busy       (busy_a),
        .rst_ack    (rst_ack_a),
        .req_merged (req_merged_a),
        .rst_count  (rst_count_a)
    );

    rst_sequencer #(.HOLD_CYCLES(H), .SETTLE_CYCLES(S_B), .COUNT_W(CW)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .rst_req    (rst_req),
        .dut_reset  (dut_reset_b),
        .busy       (busy_b),
        .rst_ack    (rst_ack_b),
        .req_merged (req_merged_b),
        .rst_count  (rst_count_b)
    );

    always #5 clk = ~clk;

    function automatic int settle_of(input int i);
        return (i == 0) ? S_A : S_B;
    endfunction

    task automatic note_busy_req(input int i);
        if (m_pend[i] != 0) m_merged[i] = 1;
        else m_pend[i] = 1;
    endtask

    // Advance the model across one rising edge with the sampled inputs
    task automatic model_step(input int i, input logic rs, input logic rq);
        int s;
        int c;
        s = settle_of(i);
        c = cyc - 1;
        if (rs) begin
            m_kind[i]   = K_POR;
            m_start[i]  = cyc;
            m_pend[i]   = 0;
            m_merged[i] = 0;
            m_count[i]  = 0;
            return;
        end
        if (m_kind[i] == K_IDLE) begin
            if (rq || m_pend[i] != 0) begin
                if (rq && m_pend[i] != 0) m_merged[i] = 1;
                m_pend[i]  = 0;
                m_kind[i]  = K_REQ;
                m_start[i] = cyc;
            end
        end else if (m_kind[i] == K_POR) begin
            if (rq) note_busy_req(i);
            if (c == m_start[i] + H + s - 1) m_kind[i] = K_IDLE;
        end else begin
            if (c == m_start[i] + H + s) begin
                if (rq && m_pend[i] != 0) m_merged[i] = 1;
                if (rq || m_pend[i] != 0) begin
                    m_pend[i]  = 0;
                    m_start[i] = cyc;
                end else begin
                    m_kind[i] = K_IDLE;
                end
            end else if (rq) begin
                note_busy_req(i);
            end
        end
        if (m_kind[i] == K_REQ && cyc == m_start[i] + H + s && m_count[i] < SAT)
            m_count[i] = m_count[i] + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_dut(input int i, input logic dr, input logic bz, input logic ak,
                             input logic mg, input logic [CW-1:0] ct);
        logic e_dr, e_bz, e_ak;
        int   s;
        s    = settle_of(i);
        e_bz = (m_kind[i] != K_IDLE);
        e_dr = (m_kind[i] != K_IDLE) && (cyc - m_start[i] < H);
        e_ak = (m_kind[i] == K_REQ) && (cyc == m_start[i] + H + s);
        chk($sformatf("d%0d_dut_reset", i), 32'(dr), 32'(e_dr));
        chk($sformatf("d%0d_busy", i),      32'(bz), 32'(e_bz));
        chk($sformatf("d%0d_rst_ack", i),   32'(ak), 32'(e_ak));
        chk($sformatf("d%0d_req_merged", i), 32'(mg), 32'(m_merged[i] != 0));
        chk($sformatf("d%0d_rst_count", i), 32'(ct), 32'(m_count[i]));
    endtask

    // Drive inputs for the current cycle, take one edge, then check both instances
    task automatic step(input logic rs, input logic rq);
        reset   = rs;
        rst_req = rq;
        @(posedge clk);
        cyc++;
        model_step(0, rs, rq);
        model_step(1, rs, rq);
        #1;
        check_dut(0, dut_reset_a, busy_a, rst_ack_a, req_merged_a, rst_count_a);
        check_dut(1, dut_reset_b, busy_b, rst_ack_b, req_merged_b, rst_count_b);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_kind[i]   = K_POR;
            m_start[i]  = 0;
            m_pend[i]   = 0;
            m_merged[i] = 0;
            m_count[i]  = 0;
        end

        // Power-on: reset in cycles 0-1, single request in cycle 20
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        idle(18);
        step(1'b0, 1'b1);
        idle(15);

        // Back-to-back: second request lands during SETTLE
        step(1'b0, 1'b1);
        idle(3);
        step(1'b0, 1'b1);
        idle(15);

        // Merge: third request collapses into the pending one
        step(1'b0, 1'b1);
        idle(1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        idle(16);
        chk("merge_sticky", 32'(req_merged_a), 32'(1));

        // Reset mid-sequence
        step(1'b0, 1'b1);
        idle(2);
        step(1'b1, 1'b0);
        idle(12);
        chk("abort_count", 32'(rst_count_a), 32'(0));

        // Saturation of the completion counter
        repeat (20) begin
            step(1'b0, 1'b1);
            idle(9);
        end
        chk("sat_count", 32'(rst_count_a), 32'(SAT));

        // Request during POR, request coincident with reset, level-high request
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        idle(15);
        step(1'b1, 1'b1);
        idle(10);
        repeat (8) step(1'b0, 1'b1);
        idle(15);

        // Randomized traffic with occasional resets
        repeat (3000) begin
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 4) == 0));
        end
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
